addsub_4bit: RTL and testbench
==============================

ADDSUB_4BIT -- requirements
Module: addsub_4bit

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 4 bits via package constant ADDSUB_W = 4.
REQ-002 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 Port in_vld, input, 1, operands valid this cycle.
REQ-005 Port A, input, 4, first operand, two's complement.
REQ-006 Port B, input, 4, second operand, two's complement.
REQ-007 Port sub, input, 1; 1 = A - B, 0 = A + B.
REQ-008 Port Sum, output, 4, registered result.
REQ-009 Port Ovfl, output, 1, registered signed-overflow flag for Sum.
REQ-010 Port out_vld, output, 1, Sum/Ovfl updated from a valid operation on the previous edge.

Function
REQ-011 The adder SHALL be a 4-stage ripple-carry chain of 1-bit full adders; stage i inputs are A[i], B[i] XOR sub, and the carry from stage i-1.
REQ-012 Carry-in to bit 0 SHALL equal sub, so subtraction is A + ~B + 1.
REQ-013 Raw result SHALL be the 4 sum bits; the carry out of bit 3 SHALL be discarded, giving modulo-16 wrap.
REQ-014 Overflow SHALL be carry into bit 3 XOR carry out of bit 3; equivalently, add: A[3]==B[3] and result[3]!=A[3]; subtract: A[3]!=B[3] and result[3]!=A[3].
REQ-015 On a rising clk edge with in_vld=1, Sum and Ovfl SHALL load the result of that cycle's A, B and sub; latency is exactly 1 cycle.
REQ-016 On a rising edge with in_vld=0, Sum and Ovfl SHALL hold their values.
REQ-017 out_vld SHALL be in_vld registered on every rising edge.
REQ-018 Back-to-back in_vld=1 SHALL give one result per cycle with no bubbles and no back-pressure.
REQ-019 Operand or sub changes between edges SHALL have no effect on the outputs until the next edge.

Reset
REQ-020 While rst_n=0, Sum SHALL be 4'b0000, Ovfl 0 and out_vld 0, immediately and independent of clk.
REQ-021 If rst_n is asserted while in_vld=1, the in-flight operation SHALL be lost; the first capture after deassertion is the first rising edge with rst_n=1.

Configuration
REQ-022 Macro ADDSUB_SAT_EN SHALL select saturation when defined.
REQ-023 With ADDSUB_SAT_EN defined, an overflowing result SHALL be replaced by 4'b0111 if A[3]=0, or 4'b1000 if A[3]=1; Ovfl is still 1.
REQ-024 Without ADDSUB_SAT_EN, the wrapped result of REQ-013 SHALL be registered; no saturation logic is present.

Structure
REQ-025 Package addsub_pkg SHALL hold ADDSUB_W, SAT_MAX = 4'b0111 and SAT_MIN = 4'b1000.
REQ-026 Sub-module full_adder_1bit (inputs a, b, cin; outputs s, cout) SHALL be instantiated 4 times; the top level holds the B inversion, overflow logic, optional saturation and output registers.

Verification
REQ-027 A=1111, B=0111, sub=0, in_vld=1 -> after 1 edge, Sum=0110, Ovfl=0, out_vld=1.
REQ-028 A=1111, B=0111, sub=1 -> Sum=1000, Ovfl=0 (-1-7=-8, no overflow).
REQ-029 A=0111, B=0001, sub=0 -> Ovfl=1; Sum=1000 without the macro, 0111 with ADDSUB_SAT_EN.
REQ-030 A=1000, B=0001, sub=1 -> Ovfl=1; Sum=0111 without the macro, 1000 with ADDSUB_SAT_EN.
REQ-031 Load 0011+0010 (Sum=0101), then in_vld=0 with new operands for 3 cycles -> Sum stays 0101, out_vld=0.
REQ-032 Assert rst_n=0 mid-cycle with in_vld=1 -> Sum=0000, Ovfl=0, out_vld=0 before the next edge; normal operation resumes after release.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared constants and types for the 4-bit registered adder/subtractor.
package addsub_pkg;

    localparam int ADDSUB_W = 4;

    localparam logic [ADDSUB_W-1:0] SAT_MAX = 4'b0111;
    localparam logic [ADDSUB_W-1:0] SAT_MIN = 4'b1000;

    // One operation as presented on the input ports
    typedef struct packed {
        logic [ADDSUB_W-1:0] a;
        logic [ADDSUB_W-1:0] b;
        logic                sub;
    } addsub_req_t;

    // Registered result
    typedef struct packed {
        logic [ADDSUB_W-1:0] sum;
        logic                ovfl;
    } addsub_rsp_t;

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full adder; one ripple stage of the add/sub chain.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addsub_4bit.sv
// 4-bit two's complement add/subtract with a one-cycle registered result.
// Ripple-carry chain of full_adder_1bit stages; subtract is A + ~B + 1.
// Optional build macro ADDSUB_SAT_EN clamps overflowing results to
// SAT_MAX / SAT_MIN instead of wrapping.
module addsub_4bit
    import addsub_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_vld,
    input  logic [ADDSUB_W-1:0] A,
    input  logic [ADDSUB_W-1:0] B,
    input  logic                sub,
    output logic [ADDSUB_W-1:0] Sum,
    output logic                Ovfl,
    output logic                out_vld
);

    addsub_req_t         req;
    addsub_rsp_t         rsp_nxt;
    logic [ADDSUB_W-1:0] b_eff;
    logic [ADDSUB_W-1:0] raw;
    logic [ADDSUB_W:0]   carry;

    assign req = '{a: A, b: B, sub: sub};

    // Conditional inversion plus carry-in of sub turns the adder into A - B
    assign b_eff    = req.b ^ {ADDSUB_W{req.sub}};
    assign carry[0] = req.sub;

    genvar i;
    generate
        for (i = 0; i < ADDSUB_W; i++) begin : g_fa
            full_adder_1bit u_fa (
                .a    (req.a[i]),
                .b    (b_eff[i]),
                .cin  (carry[i]),
                .s    (raw[i]),
                .cout (carry[i+1])
            );
        end
    endgenerate

    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    // The carry out itself is otherwise dropped, giving modulo-16 wrap.
    assign rsp_nxt.ovfl = carry[ADDSUB_W-1] ^ carry[ADDSUB_W];

`ifdef ADDSUB_SAT_EN
    // Clamp toward the sign of A; an overflow always leaves the range on A's side
    always_comb begin
        rsp_nxt.sum = raw;
        if (rsp_nxt.ovfl)
            rsp_nxt.sum = req.a[ADDSUB_W-1] ? SAT_MIN : SAT_MAX;
    end
`else
    assign rsp_nxt.sum = raw;
`endif

    // Result registers load only on a valid operation, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum  <= '0;
            Ovfl <= 1'b0;
        end else if (in_vld) begin
            Sum  <= rsp_nxt.sum;
            Ovfl <= rsp_nxt.ovfl;
        end
    end

    // Valid flag tracks in_vld with one cycle of delay, no back-pressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_vld <= 1'b0;
        else
            out_vld <= in_vld;
    end

endmodule

// File: tb/tb_addsub_4bit.sv
// Scoreboard bench for addsub_4bit: driver pushes reference results,
// monitor pops and compares whenever out_vld is seen. Honours ADDSUB_SAT_EN.
module tb_addsub_4bit;

    logic       clk;
    logic       rst_n;
    logic       in_vld;
    logic [3:0] A;
    logic [3:0] B;
    logic       sub;
    logic [3:0] Sum;
    logic       Ovfl;
    logic       out_vld;

    int vectors    = 0;
    int miscompares = 0;

    logic [4:0] exp_q[$];   // {ovfl, sum}
    logic [4:0] held;       // value the outputs should hold when idle

    addsub_4bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .A       (A),
        .B       (B),
        .sub     (sub),
        .Sum     (Sum),
        .Ovfl    (Ovfl),
        .out_vld (out_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed integer arithmetic, range check, wrap or clamp
    function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic s);
        int sa, sb, r, w;
        logic ov;
        logic [3:0] res;
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
        r  = s ? sa - sb : sa + sb;
        ov = (r > 7) || (r < -8);
        w  = (r + 32) % 16;
        res = w[3:0];
`ifdef ADDSUB_SAT_EN
        if (r > 7)  res = 4'd7;
        if (r < -8) res = 4'd8;
`endif
        return {ov, res};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic s);
        @(negedge clk);
        in_vld = v;
        A      = a;
        B      = b;
        sub    = s;
        if (v) exp_q.push_back(model(a, b, s));
    endtask

    // Monitor: compare on every active edge once reset is released
    initial begin
        logic [4:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (out_vld) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL out_vld_unexpected: got out_vld=1 expected no result at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sum", 32'(Sum), 32'(e[3:0]));
                        chk("ovfl", 32'(Ovfl), 32'(e[4]));
                        held = e;
                    end
                end else begin
                    chk("hold_sum", 32'(Sum), 32'(held[3:0]));
                    chk("hold_ovfl", 32'(Ovfl), 32'(held[4]));
                end
            end
        end
    end

    initial begin
        held   = '0;
        rst_n  = 1'b0;
        in_vld = 1'b0;
        A = '0; B = '0; sub = 1'b0;
        #1;
        chk("rst_sum", 32'(Sum), 0);
        chk("rst_ovfl", 32'(Ovfl), 0);
        chk("rst_out_vld", 32'(out_vld), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases
        drive(1, 4'b1111, 4'b0111, 0);   // -1 + 7 = 6
        drive(1, 4'b1111, 4'b0111, 1);   // -1 - 7 = -8
        drive(1, 4'b0111, 4'b0001, 0);   // 7 + 1 overflows
        drive(1, 4'b1000, 4'b0001, 1);   // -8 - 1 overflows
        drive(1, 4'b0011, 4'b0010, 0);   // 5, then hold it
        drive(0, 4'b0111, 4'b0111, 0);
        drive(0, 4'b1001, 4'b0110, 1);
        drive(0, 4'b1111, 4'b1111, 0);
        drive(1, 4'b1000, 4'b1000, 0);   // -16 wraps to 0
        drive(1, 4'b0000, 4'b1000, 1);   // 0 - (-8) overflows
        drive(0, 4'b0000, 4'b0000, 0);
        @(posedge clk);
        #1;
        chk("directed_out_vld_idle", 32'(out_vld), 0);

        // Reset asserted mid-cycle with an operation being presented
        @(negedge clk);
        in_vld = 1'b1;
        A = 4'b0101; B = 4'b0001; sub = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_sum", 32'(Sum), 0);
        chk("midrst_ovfl", 32'(Ovfl), 0);
        chk("midrst_out_vld", 32'(out_vld), 0);
        exp_q.delete();
        held = '0;
        in_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 4'b0110, 4'b0011, 1);   // resumes: 6 - 3 = 3

        // Randomised traffic, mostly back-to-back valid
        for (int n = 0; n < 300; n++)
            drive(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom));

        drive(0, 4'b0000, 4'b0000, 0);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
